// File: rtl/arv_pkg.sv
// Shared types for the instruction-memory path: physical address width, fetch
// response record, fault causes and the request classifier.
package arv_pkg;

  localparam int unsigned PHY_ADDR_SIZE = 32;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

  // Encodings follow mcause: 0 = instruction misaligned, 1 = instruction access fault.
  typedef enum logic [1:0] {
    INSTR_MISALIGNED   = 2'd0,
    INSTR_ACCESS_FAULT = 2'd1,
    NONE               = 2'd2
  } imem_cause_e;

  typedef struct packed {
    logic [PHY_ADDR_SIZE-1:0] addr;
    logic [31:0]              instr;
    logic                     fault;
    imem_cause_e              cause;
  } imem_rsp_t;

  // One extra bit on the range bound so base + size cannot wrap.
  function automatic imem_cause_e classify(input logic [PHY_ADDR_SIZE-1:0] addr,
                                           input logic [PHY_ADDR_SIZE-1:0] base,
                                           input logic [PHY_ADDR_SIZE-1:0] size);
    logic [PHY_ADDR_SIZE:0] a_w;
    logic [PHY_ADDR_SIZE:0] lo_w;
    logic [PHY_ADDR_SIZE:0] hi_w;
    a_w  = {1'b0, addr};
    lo_w = {1'b0, base};
    hi_w = lo_w + {1'b0, size};
    if (addr[1:0] != 2'b00) begin
      classify = INSTR_MISALIGNED;
    end else if ((a_w < lo_w) || (a_w >= hi_w)) begin
      classify = INSTR_ACCESS_FAULT;
    end else begin
      classify = NONE;
    end
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; simultaneous push and pop
// are legal at any occupancy, including full.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wptr_r;
  logic [AW-1:0]    rptr_r;
  logic [AW:0]      count_r;
  logic             full_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_s    = (count_r == (AW+1)'(DEPTH));
  assign empty_o   = (count_r == {(AW+1){1'b0}});
  assign do_pop_s  = pop_i && !empty_o;
  assign do_push_s = push_i && (!full_s || do_pop_s);
  assign data_o    = mem_r[rptr_r];
  assign count_o   = count_r;

  // Storage cleared on reset so the head reads as zero until written.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (do_push_s && !flush_i) begin
      mem_r[wptr_r] <= data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      count_r <= {(AW+1){1'b0}};
    end else if (flush_i) begin
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      count_r <= {(AW+1){1'b0}};
    end else begin
      if (do_push_s) wptr_r <= wptr_r + AW'(1);
      if (do_pop_s)  rptr_r <= rptr_r + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: classifies fetch requests, reads the SRAM for
// good ones and returns in-order responses through a credit-guarded FIFO.
module imem_responder
  import arv_pkg::*;
#(
  parameter int unsigned              DEPTH      = 2,
  parameter logic [PHY_ADDR_SIZE-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [PHY_ADDR_SIZE-1:0] SIZE_BYTES = 32'h0001_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [PHY_ADDR_SIZE-1:0] req_addr_i,
  output logic                     mem_req_o,
  output logic [PHY_ADDR_SIZE-1:0] mem_addr_o,
  input  logic [31:0]              mem_rdata_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output imem_rsp_t                rsp_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                     inflight_valid_r;
  logic [PHY_ADDR_SIZE-1:0] inflight_addr_r;
  logic                     inflight_fault_r;
  imem_cause_e              inflight_cause_r;

  logic [CW-1:0]            count_s;
  logic [CW:0]              used_s;
  logic                     empty_s;
  logic                     pop_s;
  logic                     push_s;
  logic                     accept_s;
  imem_cause_e              req_cause_s;
  logic                     req_fault_s;
  imem_rsp_t                push_rsp_s;
  logic [$bits(imem_rsp_t)-1:0] head_s;

  assign rsp_valid_o = !empty_s;
  assign rsp_o       = head_s;
  assign pop_s       = rsp_valid_o && rsp_ready_i;
  assign push_s      = inflight_valid_r && !flush_i;
  // A pop this cycle frees a slot immediately, hence the rsp_ready_i path.
  assign used_s      = {1'b0, count_s} + {{CW{1'b0}}, inflight_valid_r} - {{CW{1'b0}}, pop_s};
  assign req_cause_s = classify(req_addr_i, BASE_ADDR, SIZE_BYTES);
  assign req_fault_s = (req_cause_s != NONE);

  // Request handshake and SRAM command.
  always_comb begin
    req_ready_o = rst_ni && !flush_i && (used_s < (CW+1)'(DEPTH));
    accept_s    = req_valid_i && req_ready_o;
    mem_req_o   = accept_s && !req_fault_s;
    if (mem_req_o) begin
      mem_addr_o = req_addr_i;
    end else begin
      mem_addr_o = {PHY_ADDR_SIZE{1'b0}};
    end
  end

  // Faults carry a NOP so fetch always sees a well-formed word.
  always_comb begin
    push_rsp_s.addr  = inflight_addr_r;
    push_rsp_s.fault = inflight_fault_r;
    push_rsp_s.cause = inflight_cause_r;
    if (inflight_fault_r) begin
      push_rsp_s.instr = NOP_INSTR;
    end else begin
      push_rsp_s.instr = mem_rdata_i;
    end
  end

  // In-flight stage aligns request metadata with the SRAM's one-cycle read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_valid_r <= 1'b0;
      inflight_addr_r  <= {PHY_ADDR_SIZE{1'b0}};
      inflight_fault_r <= 1'b0;
      inflight_cause_r <= INSTR_MISALIGNED;
    end else if (flush_i) begin
      inflight_valid_r <= 1'b0;
    end else begin
      inflight_valid_r <= accept_s;
      if (accept_s) begin
        inflight_addr_r  <= req_addr_i;
        inflight_fault_r <= req_fault_s;
        inflight_cause_r <= req_cause_s;
      end
    end
  end

  sync_fifo #(
    .WIDTH ($bits(imem_rsp_t)),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push_s),
    .data_i  (push_rsp_s),
    .pop_i   (pop_s),
    .data_o  (head_s),
    .empty_o (empty_s),
    .count_o (count_s)
  );

endmodule

// File: tb/tb_imem_responder.sv
// Randomised scoreboard bench for imem_responder with an SRAM model and a
// transaction-level reference of classification, credit and latency.
module tb_imem_responder;
  import arv_pkg::*;

  localparam int unsigned DEPTH    = 2;
  localparam longint      BASE     = 64'h0000_0000;
  localparam longint      SIZE     = 64'h0001_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_addr_i = 32'h0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  imem_rsp_t   rsp_o;

  imem_responder #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_addr_i  (req_addr_i),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rdata_i (mem_rdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_o       (rsp_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int        cyc;
    imem_rsp_t rsp;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] preset [logic [31:0]];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] sram_word(input logic [31:0] a);
    if (preset.exists(a)) return preset[a];
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic bit is_good(input logic [31:0] a);
    longint la = longint'(a);
    return (la % 4 == 0) && (la >= BASE) && (la < BASE + SIZE);
  endfunction

  function automatic imem_rsp_t expected_rsp(input logic [31:0] a);
    imem_rsp_t r;
    longint la = longint'(a);
    r.addr = a;
    if (la % 4 != 0) begin
      r.fault = 1'b1; r.cause = INSTR_MISALIGNED; r.instr = 32'h0000_0013;
    end else if (la < BASE || la >= BASE + SIZE) begin
      r.fault = 1'b1; r.cause = INSTR_ACCESS_FAULT; r.instr = 32'h0000_0013;
    end else begin
      r.fault = 1'b0; r.cause = NONE; r.instr = sram_word(a);
    end
    return r;
  endfunction

  // Synchronous SRAM: unrequested cycles return junk that must never surface.
  always @(posedge clk_i) begin
    if (mem_req_o) mem_rdata_i <= sram_word(mem_addr_o);
    else           mem_rdata_i <= $urandom();
  end

  // Monitor: every cycle compare handshake, SRAM command and response head.
  always @(negedge clk_i) begin
    bit exp_valid, exp_pop, exp_ready, acc;
    cyc++;
    if (!rst_ni) begin
      check("reset_req_ready", req_ready_o, 0);
      check("reset_mem_req", mem_req_o, 0);
      check("reset_mem_addr", mem_addr_o, 0);
      check("reset_rsp_valid", rsp_valid_o, 0);
      check("reset_rsp", rsp_o, 0);
      q.delete();
    end else begin
      exp_valid = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
      check("rsp_valid", rsp_valid_o, exp_valid);
      if (exp_valid && rsp_valid_o) check("rsp_data", rsp_o, q[0].rsp);
      exp_pop   = exp_valid && rsp_ready_i;
      exp_ready = !flush_i && ((q.size() - int'(exp_pop)) < int'(DEPTH));
      check("req_ready", req_ready_o, exp_ready);
      acc = req_valid_i && exp_ready;
      check("mem_req", mem_req_o, acc && is_good(req_addr_i));
      if (acc && is_good(req_addr_i)) check("mem_addr", mem_addr_o, req_addr_i);
      if (flush_i) begin
        q.delete();
      end else begin
        if (exp_pop) void'(q.pop_front());
        if (acc) q.push_back('{cyc: cyc, rsp: expected_rsp(req_addr_i)});
      end
    end
  end

  task automatic step(input bit v, input logic [31:0] a, input bit rr, input bit fl);
    req_valid_i = v;
    req_addr_i  = a;
    rsp_ready_i = rr;
    flush_i     = fl;
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int k = $urandom_range(0, 9);
    case (k)
      0:       return {16'h0, 14'($urandom_range(0, 16383)), 2'($urandom_range(1, 3))};
      1:       return 32'h0001_0000 | {$urandom(), 2'b00};
      2:       return ($urandom_range(0, 1) == 1) ? 32'h0000_FFFC : 32'h0001_0000;
      default: return {16'h0, 14'($urandom_range(0, 16383)), 2'b00};
    endcase
  endfunction

  initial begin
    preset[32'h0] = 32'h0000_000A;
    preset[32'h4] = 32'h0000_000B;
    preset[32'h8] = 32'h0000_000C;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Back-to-back good reads.
    step(1, 32'h0, 1, 0); step(1, 32'h4, 1, 0); step(1, 32'h8, 1, 0);
    repeat (3) step(0, 32'h0, 1, 0);

    // Faults and range boundaries.
    step(1, 32'h6, 1, 0); step(1, 32'h0001_0002, 1, 0);
    step(1, 32'h0001_0000, 1, 0); step(1, 32'h0000_FFFC, 1, 0);
    repeat (3) step(0, 32'h0, 1, 0);

    // Backpressure fills credit, then drain with request held.
    for (int i = 0; i < 5; i++) step(1, 32'h100 + 32'(i * 4), 0, 0);
    for (int i = 0; i < 4; i++) step(1, 32'h200 + 32'(i * 4), 1, 0);
    repeat (3) step(0, 32'h0, 1, 0);

    // Flush with one buffered and one in flight.
    step(1, 32'h40, 0, 0); step(1, 32'h44, 0, 0);
    step(0, 32'h0, 0, 1);
    step(1, 32'h20, 1, 0);
    repeat (3) step(0, 32'h0, 1, 0);

    // Asynchronous reset mid-stream, then a cold-start request.
    step(1, 32'h80, 0, 0); step(1, 32'h84, 0, 0);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_req_ready", req_ready_o, 0);
    check("async_rst_rsp_valid", rsp_valid_o, 0);
    check("async_rst_rsp", rsp_o, 0);
    check("async_rst_mem_req", mem_req_o, 0);
    @(posedge clk_i); @(posedge clk_i);
    #1 rst_ni = 1'b1;
    step(1, 32'h8, 1, 0);
    repeat (3) step(0, 32'h0, 1, 0);

    // Randomised traffic with backpressure and occasional flushes.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 3) != 0,
           $urandom_range(0, 49) == 0);
    end

    // Bounded drain.
    for (int i = 0; i < 20 && q.size() > 0; i++) step(0, 32'h0, 1, 0);
    check("drain_outstanding", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
